// File: rtl/uart_defs_pkg.sv
// Shared UART definitions: frame state encoding, parity modes and the tick divisor
// calculation used by both the transmit and receive controllers.
package uart_defs_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Clock cycles between oversampling ticks; 0 flags an unusable rate setting.
  function automatic int calc_tick_div(input int clock_hz, input int baud, input int osr);
    if (osr <= 0 || baud <= 0) return 0;
    return clock_hz / (osr * baud);
  endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Oversampling tick generator: one-cycle enable every TICK_DIV clocks, restartable
// from zero so bit timing can be referenced to an arbitrary edge.
module uart_tick_gen #(
  parameter int TICK_DIV = 54
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic clear_in,
  output logic tick_out
);

  localparam int CNT_W = $clog2(TICK_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             at_wrap;

  assign at_wrap  = (cnt_q == CNT_W'(TICK_DIV - 1));
  assign tick_out = at_wrap && !clear_in;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_in || at_wrap) cnt_d = '0;
    else                     cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: accepts a word on a valid/ready handshake and shifts it out
// LSB first as start, data, optional parity and stop bits, all outputs registered.
module uart_tx_ctrl
  import uart_defs_pkg::*;
#(
  parameter int BAUD_RATE         = 230_400,
  parameter int CLOCK_IN          = 100_000_000,
  parameter int OVERSAMPLING_RATE = 8,
  parameter int DATA_BITS         = 8,
  parameter int PARITY            = 0,
  parameter int STOP_BITS         = 1
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 valid_in,
  output logic                 ready_out,
  output logic                 tx_out,
  output logic                 busy_out,
  output logic                 done_out
);

  localparam int TICK_DIV = calc_tick_div(CLOCK_IN, BAUD_RATE, OVERSAMPLING_RATE);
  localparam int OS_W     = (OVERSAMPLING_RATE >= 2) ? $clog2(OVERSAMPLING_RATE) : 1;
  localparam int BIT_W    = 4;

  if (TICK_DIV < 2) begin : g_bad_tick_div
    $error("uart_tx_ctrl: TICK_DIV must be at least 2");
  end
  if (OVERSAMPLING_RATE < 2) begin : g_bad_osr
    $error("uart_tx_ctrl: OVERSAMPLING_RATE must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_ctrl: DATA_BITS must be 5..9");
  end
  if (PARITY < PARITY_NONE || PARITY > PARITY_ODD) begin : g_bad_parity
    $error("uart_tx_ctrl: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_ctrl: STOP_BITS must be 1 or 2");
  end

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [OS_W-1:0]      os_q, os_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 tick;
  logic                 bit_end;

  // Tick phase restarts on the acceptance edge because the counter is held at zero in idle.
  uart_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .clear_in(state_q == ST_IDLE),
    .tick_out(tick)
  );

  assign bit_end = tick && (os_q == OS_W'(OVERSAMPLING_RATE - 1));

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    par_d   = par_q;
    tx_d    = tx_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (state_q == ST_IDLE) os_d = '0;
    else if (tick)          os_d = bit_end ? '0 : os_q + 1'b1;
    else                    os_d = os_q;

    case (state_q)
      ST_IDLE: begin
        tx_d    = 1'b1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        if (valid_in && ready_q) begin
          state_d = ST_START;
          shift_d = data_in;
          par_d   = (^data_in) ^ (PARITY == PARITY_ODD);
          bit_d   = '0;
          tx_d    = 1'b0;
          ready_d = 1'b0;
          busy_d  = 1'b1;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == BIT_W'(DATA_BITS - 1)) begin
            bit_d = '0;
            if (PARITY != PARITY_NONE) begin
              state_d = ST_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = ST_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_q + 1'b1;
            tx_d  = shift_q[1];
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_d = ST_STOP;
          bit_d   = '0;
          tx_d    = 1'b1;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (bit_q == BIT_W'(STOP_BITS - 1)) begin
            state_d = ST_IDLE;
            bit_d   = '0;
            done_d  = 1'b1;
            ready_d = 1'b1;
            busy_d  = 1'b0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      os_q    <= '0;
      bit_q   <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      os_q    <= os_d;
      bit_q   <= bit_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx_out    = tx_q;
  assign ready_out = ready_q;
  assign busy_out  = busy_q;
  assign done_out  = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: four configurations, frames checked bit by bit at the
// first and last cycle of every bit period, plus handshake, back-to-back and reset cases.
module tb_uart_tx_ctrl;

  localparam int BIT_P = 432;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [8:0] data_r = '0;
  logic [3:0] valid_r = '0;
  logic [3:0] tx_w, ready_w, busy_w, done_w;
  int         n_tests = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  uart_tx_ctrl u_def (
    .clk_in(clk), .rst_in(rst), .data_in(data_r[7:0]), .valid_in(valid_r[0]),
    .ready_out(ready_w[0]), .tx_out(tx_w[0]), .busy_out(busy_w[0]), .done_out(done_w[0])
  );
  uart_tx_ctrl #(.PARITY(1)) u_even (
    .clk_in(clk), .rst_in(rst), .data_in(data_r[7:0]), .valid_in(valid_r[1]),
    .ready_out(ready_w[1]), .tx_out(tx_w[1]), .busy_out(busy_w[1]), .done_out(done_w[1])
  );
  uart_tx_ctrl #(.PARITY(2)) u_odd (
    .clk_in(clk), .rst_in(rst), .data_in(data_r[7:0]), .valid_in(valid_r[2]),
    .ready_out(ready_w[2]), .tx_out(tx_w[2]), .busy_out(busy_w[2]), .done_out(done_w[2])
  );
  uart_tx_ctrl #(.DATA_BITS(5), .STOP_BITS(2)) u_s2 (
    .clk_in(clk), .rst_in(rst), .data_in(data_r[4:0]), .valid_in(valid_r[3]),
    .ready_out(ready_w[3]), .tx_out(tx_w[3]), .busy_out(busy_w[3]), .done_out(done_w[3])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("[TB] ok %s = %0h", tag, obs);
    end
  endtask

  // exp holds the expected line level of bit period k in bit k (start bit at bit 0).
  // hold keeps valid high through the frame so the next frame is offered on the done cycle.
  task automatic send_frame(input int idx, input logic [8:0] d, input logic [15:0] exp,
                            input int nb, input bit hold, input string tag);
    int guard;
    int k;
    int ph;
    guard = 0;
    while (!ready_w[idx] && guard < 10000) begin
      @(negedge clk);
      guard++;
    end
    check({tag, " ready_before"}, 32'(ready_w[idx]), 32'd1);
    data_r       = d;
    valid_r[idx] = 1'b1;
    @(posedge clk);
    for (int j = 0; j <= nb * BIT_P; j++) begin
      @(negedge clk);
      if (j == 0 && !hold) valid_r[idx] = 1'b0;
      if (j < nb * BIT_P) begin
        k  = j / BIT_P;
        ph = j % BIT_P;
        if (ph == 0 || ph == BIT_P - 1)
          check($sformatf("%s bit%0d@%0d", tag, k, ph), 32'(tx_w[idx]), 32'(exp[k]));
        if (ph == BIT_P / 2)
          check($sformatf("%s busy/ready bit%0d", tag, k),
                {30'd0, busy_w[idx], ready_w[idx]}, 32'b10);
        if (j == nb * BIT_P - 1)
          check({tag, " done_early"}, 32'(done_w[idx]), 32'd0);
        if (!hold && (j % 700) == 350) begin
          data_r       = 9'($urandom);
          valid_r[idx] = ~valid_r[idx];
        end
      end else begin
        check({tag, " done/ready/busy/tx"},
              {28'd0, done_w[idx], ready_w[idx], busy_w[idx], tx_w[idx]}, 32'b1101);
        if (!hold) valid_r[idx] = 1'b0;
      end
    end
  endtask

  initial begin
    bit saw_done;
    repeat (3) @(negedge clk);
    check("reset outputs", {28'd0, tx_w[0], ready_w[0], busy_w[0], done_w[0]}, 32'b1100);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // 0xA5, 8N1: 0,1,0,1,0,0,1,0,1,1
    send_frame(0, 9'h0A5, 16'h034A, 10, 1'b0, "a5");
    // back-to-back 0x55 then 0x0F with valid held high across the done cycle
    send_frame(0, 9'h055, 16'h02AA, 10, 1'b1, "b2b_55");
    send_frame(0, 9'h00F, 16'h021E, 10, 1'b0, "b2b_0f");
    repeat (5) @(negedge clk);

    // asynchronous reset in the middle of data bit 1 of 0x3C
    data_r     = 9'h03C;
    valid_r[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_r[0] = 1'b0;
    repeat (1000) @(negedge clk);
    check("rst pre tx", 32'(tx_w[0]), 32'd0);
    #3 rst = 1'b1;
    #1 check("rst async", {28'd0, tx_w[0], ready_w[0], busy_w[0], done_w[0]}, 32'b1100);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (4500) begin
      @(negedge clk);
      saw_done |= done_w[0];
    end
    check("rst no done", 32'(saw_done), 32'd0);
    send_frame(0, 9'h0A5, 16'h034A, 10, 1'b0, "a5_after_rst");

    // 0x07 with even parity (bit 1) and odd parity (bit 0)
    send_frame(1, 9'h007, 16'h060E, 11, 1'b0, "even_07");
    send_frame(2, 9'h007, 16'h040E, 11, 1'b0, "odd_07");
    // 5 data bits, 2 stop bits, 0x1F: 0 then seven 1s
    send_frame(3, 9'h01F, 16'h00FE, 8, 1'b0, "s2_1f");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
